// File: rtl/ws2812b_receiver_if.sv
// Signal bundle between a WS2812B line decoder and its consumer.
// The decoder takes the raw line and drives the decoded words and status strobes.
interface ws2812b_receiver_if;
    logic        din;
    logic [23:0] rgb_data;
    logic        rgb_valid;
    logic [7:0]  led_index;
    logic        frame_done;
    logic        pulse_err;
    logic        busy;

    modport master (
        input  din,
        output rgb_data, rgb_valid, led_index, frame_done, pulse_err, busy
    );

    modport slave (
        output din,
        input  rgb_data, rgb_valid, led_index, frame_done, pulse_err, busy
    );
endinterface

// File: rtl/ws2812b_receiver.sv
// WS2812B single-wire decoder: classifies high pulses by width, assembles GRB words,
// presents them as RGB with a per-LED index, and detects the 50 us frame gap.
module ws2812b_receiver #(
    parameter int SYS_FREQ = 12_090_000
) (
    input  logic                clk,
    input  logic                rst,
    ws2812b_receiver_if.master  bus
);

    localparam logic [15:0] T_SPLIT    = 16'((SYS_FREQ * 6)  / 10_000_000);
    localparam logic [15:0] MIN_HIGH   = 16'((SYS_FREQ * 2)  / 10_000_000);
    localparam logic [15:0] MAX_HIGH   = 16'((SYS_FREQ * 15) / 10_000_000);
    localparam logic [15:0] RESET_TIME = 16'((SYS_FREQ * 50) / 1_000_000);

    typedef enum logic [1:0] {WAIT_GAP, IDLE, HIGH, LOW} state_t;

    state_t      state, state_n;
    logic        din_meta, din_sync, din_prev;
    logic        rise, fall;
    logic [15:0] hi_cnt, lo_cnt, hi_inc, lo_inc;
    logic [4:0]  bit_cnt;
    logic [23:0] sh;
    logic        start, shift, err, frame_end;

    logic [23:0] rgb_data_q;
    logic        rgb_valid_q, frame_done_q, pulse_err_q, busy_q;
    logic [7:0]  led_index_q;

    assign rise   = din_sync & ~din_prev;
    assign fall   = ~din_sync & din_prev;
    assign hi_inc = (hi_cnt == 16'hFFFF) ? hi_cnt : hi_cnt + 16'd1;
    assign lo_inc = (lo_cnt == 16'hFFFF) ? lo_cnt : lo_cnt + 16'd1;

    // din_meta may go metastable; only din_sync and later are used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_meta <= 1'b0;
            din_sync <= 1'b0;
            din_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking so each flop takes the previous stage's old value,
            // giving a real three-stage pipeline rather than one wire.
            din_meta <= bus.din;
            din_sync <= din_meta;
            din_prev <= din_sync;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_GAP;
        else     state <= state_n;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_n   = state;
        start     = 1'b0;
        shift     = 1'b0;
        err       = 1'b0;
        frame_end = 1'b0;
        case (state)
            WAIT_GAP: if (!din_sync && lo_inc >= RESET_TIME) state_n = IDLE;
            IDLE: if (rise) begin
                start   = 1'b1;
                state_n = HIGH;
            end
            HIGH: if (fall) begin
                if (hi_cnt < MIN_HIGH) begin
                    err     = 1'b1;
                    state_n = WAIT_GAP;
                end else begin
                    shift   = 1'b1;
                    state_n = LOW;
                end
            end else if (hi_inc > MAX_HIGH) begin
                err     = 1'b1;
                state_n = WAIT_GAP;
            end
            // A rise on the gap's final cycle wins: it is the next bit, not a frame end.
            LOW: if (rise) begin
                state_n = HIGH;
            end else if (lo_inc >= RESET_TIME) begin
                frame_end = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = WAIT_GAP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_cnt       <= '0;
            lo_cnt       <= '0;
            bit_cnt      <= '0;
            sh           <= '0;
            rgb_data_q   <= '0;
            rgb_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pulse_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            led_index_q  <= '0;
        end else begin
            rgb_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pulse_err_q  <= 1'b0;

            // Counters restart on the edge that opens their pulse.
            hi_cnt <= rise ? 16'd1 : (din_sync ? hi_inc : hi_cnt);
            lo_cnt <= din_sync ? 16'd0 : (fall ? 16'd1 : lo_inc);

            if (start) busy_q <= 1'b1;

            if (shift) begin
                sh      <= {sh[22:0], hi_cnt >= T_SPLIT};
                bit_cnt <= bit_cnt + 5'd1;
            end

            // Wire order is G,R,B; present as R,G,B.
            if (bit_cnt == 5'd24) begin
                rgb_valid_q <= 1'b1;
                rgb_data_q  <= {sh[15:8], sh[23:16], sh[7:0]};
                bit_cnt     <= '0;
            end

            if (rgb_valid_q && led_index_q != 8'hFF) led_index_q <= led_index_q + 8'd1;

            if (frame_end) begin
                frame_done_q <= 1'b1;
                pulse_err_q  <= (bit_cnt != 5'd0);
            end
            if (err) pulse_err_q <= 1'b1;

            if (err || frame_end) begin
                sh          <= '0;
                bit_cnt     <= '0;
                led_index_q <= '0;
                busy_q      <= 1'b0;
            end
        end
    end

    assign bus.rgb_data   = rgb_data_q;
    assign bus.rgb_valid  = rgb_valid_q;
    assign bus.led_index  = led_index_q;
    assign bus.frame_done = frame_done_q;
    assign bus.pulse_err  = pulse_err_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ws2812b_receiver.sv
// Directed bench for ws2812b_receiver: drives WS2812B waveforms on din and
// compares decoded words and strobes against hand-computed values.
module tb_ws2812b_receiver;

    logic clk = 1'b0;
    logic rst;

    ws2812b_receiver_if bus ();

    ws2812b_receiver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int fd_cnt   = 0;
    int pe_cnt   = 0;
    int both_cnt = 0;
    int long_cnt = 0;
    logic [23:0] word_data[$];
    logic [7:0]  word_idx[$];
    logic prev_v  = 1'b0;
    logic prev_fd = 1'b0;
    logic prev_pe = 1'b0;

    int w0, fd0, pe0, b0;

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.rgb_valid) begin
            word_data.push_back(bus.rgb_data);
            word_idx.push_back(bus.led_index);
        end
        if (bus.frame_done) fd_cnt++;
        if (bus.pulse_err) pe_cnt++;
        if (bus.frame_done && bus.pulse_err) both_cnt++;
        if ((bus.rgb_valid && prev_v) || (bus.frame_done && prev_fd) || (bus.pulse_err && prev_pe))
            long_cnt++;
        prev_v  = bus.rgb_valid;
        prev_fd = bus.frame_done;
        prev_pe = bus.pulse_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int i);
        return (i < word_data.size()) ? {8'h00, word_data[i]} : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] wi(input int i);
        return (i < word_idx.size()) ? {24'h0, word_idx[i]} : 32'hDEAD_BEEF;
    endfunction

    task automatic snap();
        w0  = word_data.size();
        fd0 = fd_cnt;
        pe0 = pe_cnt;
        b0  = both_cnt;
    endtask

    task automatic hold(input logic v, input int n);
        bus.din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pulse(input int hi, input int lo);
        hold(1'b1, hi);
        hold(1'b0, lo);
    endtask

    // Sends the top n bits of a wire-order GRB word, 15-clk bit period.
    task automatic send_grb_bits(input logic [23:0] grb, input int n, input int hi0, input int hi1);
        for (int i = 23; i > 23 - n; i--) begin
            if (grb[i]) send_pulse(hi1, 15 - hi1);
            else        send_pulse(hi0, 15 - hi0);
        end
    endtask

    task automatic send_rgb(input logic [23:0] rgb, input int hi0, input int hi1);
        send_grb_bits({rgb[15:8], rgb[23:16], rgb[7:0]}, 24, hi0, hi1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.din = 1'b0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        check("reset rgb_data",   {8'h0, bus.rgb_data}, 32'h0);
        check("reset rgb_valid",  {31'h0, bus.rgb_valid}, 32'h0);
        check("reset led_index",  {24'h0, bus.led_index}, 32'h0);
        check("reset frame_done", {31'h0, bus.frame_done}, 32'h0);
        check("reset pulse_err",  {31'h0, bus.pulse_err}, 32'h0);
        check("reset busy",       {31'h0, bus.busy}, 32'h0);
        rst = 1'b0;

        // 1: two-LED frame, transmitter timing
        hold(1'b0, 700);
        snap();
        send_rgb(24'hFF0000, 4, 9);
        check("t1 busy mid-frame", {31'h0, bus.busy}, 32'h1);
        send_rgb(24'h00FF00, 4, 9);
        hold(1'b0, 700);
        check("t1 word count",  word_data.size() - w0, 2);
        check("t1 word0 data",  wd(w0), 32'hFF0000);
        check("t1 word0 index", wi(w0), 32'h0);
        check("t1 word1 data",  wd(w0 + 1), 32'h00FF00);
        check("t1 word1 index", wi(w0 + 1), 32'h1);
        check("t1 frame_done",  fd_cnt - fd0, 1);
        check("t1 pulse_err",   pe_cnt - pe0, 0);
        check("t1 busy after",  {31'h0, bus.busy}, 32'h0);
        check("t1 rgb_data hold", {8'h0, bus.rgb_data}, 32'h00FF00);
        check("t1 led_index cleared", {24'h0, bus.led_index}, 32'h0);

        // 2: pulses on either side of the 0/1 split
        snap();
        send_rgb(24'hAAAAAA, 6, 7);
        send_rgb(24'h3C0F81, 6, 7);
        hold(1'b0, 700);
        check("t2 word0 data",  wd(w0), 32'hAAAAAA);
        check("t2 word1 data",  wd(w0 + 1), 32'h3C0F81);
        check("t2 word1 index", wi(w0 + 1), 32'h1);
        check("t2 frame_done",  fd_cnt - fd0, 1);
        check("t2 pulse_err",   pe_cnt - pe0, 0);

        // 3: 1-clk glitch mid-word, then exactly 604 low cycles before the next word
        snap();
        send_grb_bits(24'hF0F0F0, 5, 4, 9);
        send_pulse(1, 604);
        check("t3 glitch pulse_err", pe_cnt - pe0, 1);
        check("t3 glitch no word",   word_data.size() - w0, 0);
        check("t3 busy dropped",     {31'h0, bus.busy}, 32'h0);
        send_rgb(24'h123456, 4, 9);
        hold(1'b0, 700);
        check("t3 recovered data",  wd(w0), 32'h123456);
        check("t3 recovered index", wi(w0), 32'h0);
        check("t3 frame_done",      fd_cnt - fd0, 1);
        check("t3 total pulse_err", pe_cnt - pe0, 1);

        // 4: over-long high pulse
        snap();
        hold(1'b1, 30);
        hold(1'b0, 5);
        check("t4 overlong pulse_err", pe_cnt - pe0, 1);
        check("t4 busy dropped",       {31'h0, bus.busy}, 32'h0);
        hold(1'b0, 700);
        check("t4 no frame_done",      fd_cnt - fd0, 0);
        send_rgb(24'h0000FF, 4, 9);
        hold(1'b0, 700);
        check("t4 next frame data",  wd(w0), 32'h0000FF);
        check("t4 next frame_done",  fd_cnt - fd0, 1);

        // 5: truncated word at frame end
        snap();
        send_grb_bits(24'hABCDEF, 12, 4, 9);
        hold(1'b0, 604);
        hold(1'b0, 20);
        check("t5 frame_done",       fd_cnt - fd0, 1);
        check("t5 pulse_err",        pe_cnt - pe0, 1);
        check("t5 same-cycle strobe", both_cnt - b0, 1);
        check("t5 no word",          word_data.size() - w0, 0);

        // 6: reset in the middle of the second word
        snap();
        send_rgb(24'h111111, 4, 9);
        send_grb_bits(24'hFFFFFF, 10, 4, 9);
        check("t6 busy before rst",  {31'h0, bus.busy}, 32'h1);
        check("t6 index before rst", {24'h0, bus.led_index}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("t6 rst rgb_data",  {8'h0, bus.rgb_data}, 32'h0);
        check("t6 rst busy",      {31'h0, bus.busy}, 32'h0);
        check("t6 rst led_index", {24'h0, bus.led_index}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        hold(1'b0, 700);
        send_rgb(24'hC0FFEE, 4, 9);
        hold(1'b0, 700);
        check("t6 word count",  word_data.size() - w0, 2);
        check("t6 new data",    wd(w0 + 1), 32'hC0FFEE);
        check("t6 new index",   wi(w0 + 1), 32'h0);
        check("t6 pulse_err",   pe_cnt - pe0, 0);
        check("t6 frame_done",  fd_cnt - fd0, 1);

        check("strobes single-cycle", long_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
